mcdt_rx_demux: RTL and testbench
================================

// Module: mcdt_rx_demux
// PURPOSE
//  Receive-side counterpart of the MCDT arbiter output stream. Takes the
//  arbitrated word stream (data/val/id), demultiplexes it by channel id into
//  three per-channel receive FIFOs, and presents each channel to a downstream
//  reader through a valid/ready handshake. Sits after mcdt; the stream has no
//  backpressure, so overflow and illegal ids are flagged, never stalled.
// PARAMETERS
//  DEPTH  32  entries per channel FIFO; power of 2, >= 2
//  DW     32  data width; equals mcdt_data_o width
// PORTS
//  clk_i         in   1            single clock, all logic on posedge
//  rst_i         in   1            synchronous reset, active-high
//  mcdt_data_i   in   DW           stream data from mcdt_data_o
//  mcdt_val_i    in   1            stream word valid (from mcdt_val_o)
//  mcdt_id_i     in   2            channel id of the word, legal 0..2
//  chN_data_o    out  DW           N=0..2: head-of-FIFO data
//  chN_valid_o   out  1            N=0..2: FIFO non-empty
//  chN_ready_i   in   1            N=0..2: reader accepts the head word
//  chN_count_o   out  log2(DEPTH)+1  N=0..2: current occupancy, 0..DEPTH
//  ovf_o         out  3            sticky per-channel overflow (word dropped)
//  bad_id_o      out  1            sticky: word received with id==3
//  clr_i         in   1            clears ovf_o and bad_id_o
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): all pointers and counts 0; chN_valid_o=0,
//    chN_data_o=0, chN_count_o=0, ovf_o=0, bad_id_o=0. Reset overrides every
//    other input that cycle. Reset mid-stream discards all buffered words.
//  - Push: mcdt_val_i=1 at posedge with id k<3 writes mcdt_data_i into FIFO k.
//  - Pop: chN_valid_o & chN_ready_i at posedge removes the head of FIFO N.
//    chN_ready_i while chN_valid_o=0 has no effect.
//  - Latency: word pushed at posedge T shows chN_valid_o=1 and data after T,
//    i.e. first-word-fall-through, 1 cycle input-to-output.
//  - chN_data_o is the head entry while valid. Otherwise it holds 0.
//    chN_data_o is stable while valid=1 and ready=0.
//  - Count: +1 on push, -1 on pop, unchanged on push+pop same cycle.
//  - Full (count==DEPTH):
//    - push with pop in the same cycle: accepted, count stays DEPTH.
//    - push without pop: word dropped, ovf_o[k] set, FIFO contents unchanged.
//  - Empty: simultaneous push+pop is impossible (valid=0), so the push is
//    accepted normally.
//  - Pointers wrap modulo DEPTH; full/empty are derived from the count,
//    never from pointer equality alone.
//  - id==3 with val=1: word dropped, bad_id_o set, no FIFO changes.
//  - Sticky flags: clr_i=1 clears them at posedge. A new error event in the
//    same cycle as clr_i wins, so that flag is set afterwards.
//  - No state machine beyond the FIFO counters; the demux is a one-hot
//    decode of mcdt_id_i gated by mcdt_val_i.
// STRUCTURE
//  - mcdt_pkg: CHNL_NUM=3, typedef logic [1:0] chnl_id_t, ID_INVALID=2'd3.
//  - Sub-module rx_chnl_fifo (DEPTH, DW), instantiated 3x. It contains the
//    FWFT storage, rd/wr pointers, count and an overflow pulse output.
//  - Top level holds the id decode plus the sticky ovf/bad_id registers.
// TESTING
//  1 Reset: hold rst_i 10 cycles with val=1 -> all outputs 0, counts 0.
//  2 Single channel: 10 words 00C0_0000..0009 on id 0, ready0=1 -> ch0 emits
//    them in order, each one cycle after input; ch1/ch2 stay valid=0.
//  3 Interleave: ids 0,1,2,0,1,2 with data 00Cn_000m, all readies=0 ->
//    counts 2/2/2; releasing readies drains each channel in per-id order.
//  4 Full: 32 words to id 1 with ready1=0 -> count1=32, ovf_o=000. 33rd word
//    00C1_0020 -> dropped, ovf_o=010, count stays 32. Drain yields exactly
//    00C1_0000..001F.
//  5 Full plus pop: count2=32, push and pop in the same cycle -> count2=32,
//    ovf_o[2]=0, new word appears last.
//  6 Bad id / clear: val=1 id=3 -> bad_id_o=1, no counts change. clr_i=1
//    alone -> 0. clr_i with another id=3 -> stays 1.

Source files
------------

// File: rtl/mcdt_pkg.sv
// Shared definitions for the MCDT receive path: channel count, id type and
// the one-hot channel select derived from the stream id.
package mcdt_pkg;

  localparam int CHNL_NUM = 3;

  typedef logic [1:0] chnl_id_t;

  // The only id value that does not map to a receive channel.
  localparam chnl_id_t ID_INVALID = 2'd3;

  // One-hot channel select for a stream word; all zero when the word is not
  // valid or carries the invalid id.
  function automatic logic [CHNL_NUM-1:0] id_decode(input logic val, input chnl_id_t id);
    logic [CHNL_NUM-1:0] sel;
    sel = '0;
    for (int i = 0; i < CHNL_NUM; i++) begin
      if (val && (id == chnl_id_t'(i))) begin
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rx_chnl_fifo.sv
// Per-channel first-word-fall-through receive FIFO. The head entry is
// presented combinationally from storage, so a word written at one edge is
// visible right after it. Full/empty come from the occupancy count, which lets
// the pointers wrap freely and makes full+push+pop a legal pass-through.
module rx_chnl_fifo #(
  parameter int DEPTH = 32,
  parameter int DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic                     rd_ready_i,
  output logic [DW-1:0]            rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_pulse_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  logic empty;
  logic full;
  logic pop;
  logic push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  // A pop only happens when there is a head word to hand over.
  assign pop     = rd_ready_i & ~empty;
  // When full, the slot freed by a same-cycle pop is reused by the push.
  assign push_ok = wr_en_i & (~full | pop);

  assign ovf_pulse_o = wr_en_i & full & ~pop;
  assign rd_valid_o  = ~empty;
  assign rd_data_o   = empty ? '0 : mem[rd_ptr_reg];
  assign count_o     = count_reg;

  // Occupancy update: push and pop in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage write; contents are not reset, pointers define what is live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) begin
      mem[wr_ptr_reg] <= wr_data_i;
    end
  end

  // Pointer and count registers; pointers wrap modulo DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/mcdt_rx_demux.sv
// Receive-side demultiplexer for the MCDT arbiter stream. Steers each valid
// word into the FIFO of its channel and exposes each FIFO through valid/ready.
// The stream cannot be stalled, so dropped words are reported through sticky
// overflow and bad-id flags that the host clears with clr_i.
module mcdt_rx_demux
  import mcdt_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int DW    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DW-1:0]          mcdt_data_i,
  input  logic                   mcdt_val_i,
  input  logic [1:0]             mcdt_id_i,
  output logic [DW-1:0]          ch0_data_o,
  output logic                   ch0_valid_o,
  input  logic                   ch0_ready_i,
  output logic [$clog2(DEPTH):0] ch0_count_o,
  output logic [DW-1:0]          ch1_data_o,
  output logic                   ch1_valid_o,
  input  logic                   ch1_ready_i,
  output logic [$clog2(DEPTH):0] ch1_count_o,
  output logic [DW-1:0]          ch2_data_o,
  output logic                   ch2_valid_o,
  input  logic                   ch2_ready_i,
  output logic [$clog2(DEPTH):0] ch2_count_o,
  output logic [2:0]             ovf_o,
  output logic                   bad_id_o,
  input  logic                   clr_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CHNL_NUM-1:0] wr_sel;
  logic [CHNL_NUM-1:0] rd_ready;
  logic [CHNL_NUM-1:0] rd_valid;
  logic [CHNL_NUM-1:0] ovf_pulse;
  logic [DW-1:0]       rd_data [CHNL_NUM];
  logic [CW-1:0]       count   [CHNL_NUM];

  logic [CHNL_NUM-1:0] ovf_reg;
  logic                bad_id_reg;
  logic                bad_id_event;

  assign wr_sel       = id_decode(mcdt_val_i, chnl_id_t'(mcdt_id_i));
  assign bad_id_event = mcdt_val_i && (chnl_id_t'(mcdt_id_i) == ID_INVALID);
  assign rd_ready     = {ch2_ready_i, ch1_ready_i, ch0_ready_i};

  generate
    for (genvar gi = 0; gi < CHNL_NUM; gi++) begin : g_chnl
      rx_chnl_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
      ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_sel[gi]),
        .wr_data_i   (mcdt_data_i),
        .rd_ready_i  (rd_ready[gi]),
        .rd_data_o   (rd_data[gi]),
        .rd_valid_o  (rd_valid[gi]),
        .count_o     (count[gi]),
        .ovf_pulse_o (ovf_pulse[gi])
      );
    end
  endgenerate

  assign ch0_data_o  = rd_data[0];
  assign ch1_data_o  = rd_data[1];
  assign ch2_data_o  = rd_data[2];
  assign ch0_valid_o = rd_valid[0];
  assign ch1_valid_o = rd_valid[1];
  assign ch2_valid_o = rd_valid[2];
  assign ch0_count_o = count[0];
  assign ch1_count_o = count[1];
  assign ch2_count_o = count[2];
  assign ovf_o       = ovf_reg;
  assign bad_id_o    = bad_id_reg;

  // Sticky error flags: clear first, then OR in this cycle's events so a new
  // event coinciding with clr_i leaves its flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_reg    <= '0;
      bad_id_reg <= 1'b0;
    end else begin
      ovf_reg    <= (clr_i ? '0 : ovf_reg) | ovf_pulse;
      bad_id_reg <= (clr_i ? 1'b0 : bad_id_reg) | bad_id_event;
    end
  end

endmodule

// File: tb/tb_mcdt_rx_demux.sv
// Scoreboard bench for mcdt_rx_demux: the stimulus side queues the words each
// channel must deliver, a negedge monitor pops and compares on every handshake.
module tb_mcdt_rx_demux;

  localparam int DEPTH = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] mcdt_data_i = '0;
  logic          mcdt_val_i = 1'b0;
  logic [1:0]    mcdt_id_i = 2'd0;
  logic [2:0]    rdy = 3'b000;
  logic          clr_i = 1'b0;

  logic [DW-1:0] ch0_data_o, ch1_data_o, ch2_data_o;
  logic          ch0_valid_o, ch1_valid_o, ch2_valid_o;
  logic [5:0]    ch0_count_o, ch1_count_o, ch2_count_o;
  logic [2:0]    ovf_o;
  logic          bad_id_o;

  int n_cmp = 0;
  int n_err = 0;

  int            mc [3];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] q2 [$];

  always #5 clk = ~clk;

  mcdt_rx_demux #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .mcdt_data_i (mcdt_data_i),
    .mcdt_val_i  (mcdt_val_i),
    .mcdt_id_i   (mcdt_id_i),
    .ch0_data_o  (ch0_data_o),
    .ch0_valid_o (ch0_valid_o),
    .ch0_ready_i (rdy[0]),
    .ch0_count_o (ch0_count_o),
    .ch1_data_o  (ch1_data_o),
    .ch1_valid_o (ch1_valid_o),
    .ch1_ready_i (rdy[1]),
    .ch1_count_o (ch1_count_o),
    .ch2_data_o  (ch2_data_o),
    .ch2_valid_o (ch2_valid_o),
    .ch2_ready_i (rdy[2]),
    .ch2_count_o (ch2_count_o),
    .ovf_o       (ovf_o),
    .bad_id_o    (bad_id_o),
    .clr_i       (clr_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [DW-1:0] d);
    case (k)
      0: q0.push_back(d);
      1: q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  // Monitor side: one comparison per accepted head word.
  task automatic mon_pop(input int k, input logic [DW-1:0] act);
    logic [DW-1:0] exp;
    int            sz;
    sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    n_cmp++;
    if (sz == 0) begin
      n_err++;
      $display("FAIL ch%0d_unexpected_pop: got %h expected no word", k, act);
    end else begin
      case (k)
        0: exp = q0.pop_front();
        1: exp = q1.pop_front();
        default: exp = q2.pop_front();
      endcase
      if (act !== exp) begin
        n_err++;
        $display("FAIL ch%0d_data: got %h expected %h", k, act, exp);
      end else begin
        $display("ch%0d pop %h", k, act);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      if (ch0_valid_o && rdy[0]) mon_pop(0, ch0_data_o);
      if (ch1_valid_o && rdy[1]) mon_pop(1, ch1_data_o);
      if (ch2_valid_o && rdy[2]) mon_pop(2, ch2_data_o);
    end
  end

  // Applies current inputs for one clock; records which words must come out.
  task automatic step();
    if (rst_i) begin
      for (int k = 0; k < 3; k++) mc[k] = 0;
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit pop;
        bit push;
        pop  = rdy[k] && (mc[k] > 0);
        push = mcdt_val_i && (int'(mcdt_id_i) == k);
        if (push && ((mc[k] < DEPTH) || pop)) begin
          push_exp(k, mcdt_data_i);
          mc[k]++;
        end
        if (pop) mc[k]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] id, input logic [DW-1:0] d);
    mcdt_val_i  = 1'b1;
    mcdt_id_i   = id;
    mcdt_data_i = d;
    step();
    mcdt_val_i  = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) mc[k] = 0;

    // 1: reset held 10 cycles with a valid word present
    rst_i       = 1'b1;
    mcdt_val_i  = 1'b1;
    mcdt_id_i   = 2'd0;
    mcdt_data_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) step();
    chk("rst_valid0", ch0_valid_o, 0);
    chk("rst_valid1", ch1_valid_o, 0);
    chk("rst_valid2", ch2_valid_o, 0);
    chk("rst_data0", ch0_data_o, 0);
    chk("rst_data1", ch1_data_o, 0);
    chk("rst_data2", ch2_data_o, 0);
    chk("rst_count0", ch0_count_o, 0);
    chk("rst_count1", ch1_count_o, 0);
    chk("rst_count2", ch2_count_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_bad_id", bad_id_o, 0);
    rst_i      = 1'b0;
    mcdt_val_i = 1'b0;
    step();

    // 2: single channel streaming with ready0 held high
    rdy = 3'b001;
    for (int i = 0; i < 10; i++) begin
      mcdt_val_i  = 1'b1;
      mcdt_id_i   = 2'd0;
      mcdt_data_i = 32'h00C0_0000 + i;
      step();
      chk("s2_valid0", ch0_valid_o, 1);
      chk("s2_head0", ch0_data_o, 32'h00C0_0000 + i);
      chk("s2_valid1", ch1_valid_o, 0);
      chk("s2_valid2", ch2_valid_o, 0);
    end
    mcdt_val_i = 1'b0;
    step();
    chk("s2_drained_valid0", ch0_valid_o, 0);
    chk("s2_drained_count0", ch0_count_o, 0);

    // 3: interleaved ids with all readers stalled, then released
    rdy = 3'b000;
    for (int j = 0; j < 6; j++) begin
      send(2'(j % 3), 32'h00C0_0000 | (32'(j % 3) << 16) | 32'(j / 3));
    end
    chk("s3_count0", ch0_count_o, 2);
    chk("s3_count1", ch1_count_o, 2);
    chk("s3_count2", ch2_count_o, 2);
    chk("s3_head1", ch1_data_o, 32'h00C1_0000);
    rdy = 3'b111;
    step();
    step();
    chk("s3_empty0", ch0_count_o, 0);
    chk("s3_empty1", ch1_count_o, 0);
    chk("s3_empty2", ch2_count_o, 0);

    // 4: fill channel 1, overflow with a 33rd word, then drain
    rdy = 3'b000;
    for (int i = 0; i < 32; i++) send(2'd1, 32'h00C1_0000 + i);
    chk("s4_full_count1", ch1_count_o, 32);
    chk("s4_full_ovf", ovf_o, 3'b000);
    send(2'd1, 32'h00C1_0020);
    chk("s4_ovf_flag", ovf_o, 3'b010);
    chk("s4_ovf_count1", ch1_count_o, 32);
    rdy = 3'b010;
    for (int i = 0; i < 32; i++) step();
    chk("s4_drain_count1", ch1_count_o, 0);
    chk("s4_drain_valid1", ch1_valid_o, 0);
    chk("s4_ovf_sticky", ovf_o, 3'b010);
    rdy   = 3'b000;
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("s4_ovf_cleared", ovf_o, 3'b000);

    // 5: channel 2 full, push and pop in the same cycle
    for (int i = 0; i < 32; i++) send(2'd2, 32'h00C2_0000 + i);
    chk("s5_full_count2", ch2_count_o, 32);
    rdy = 3'b100;
    send(2'd2, 32'h00C2_0020);
    chk("s5_pass_count2", ch2_count_o, 32);
    chk("s5_pass_ovf", ovf_o, 3'b000);
    for (int i = 0; i < 31; i++) step();
    chk("s5_last_head2", ch2_data_o, 32'h00C2_0020);
    chk("s5_last_count2", ch2_count_o, 1);
    step();
    chk("s5_empty_count2", ch2_count_o, 0);
    rdy = 3'b000;

    // 6: invalid id, clear, and clear racing a new invalid id
    send(2'd3, 32'h00C3_0000);
    chk("s6_bad_id_set", bad_id_o, 1);
    chk("s6_count0", ch0_count_o, 0);
    chk("s6_count1", ch1_count_o, 0);
    chk("s6_count2", ch2_count_o, 0);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("s6_bad_id_clr", bad_id_o, 0);
    clr_i = 1'b1;
    send(2'd3, 32'h00C3_0001);
    clr_i = 1'b0;
    chk("s6_bad_id_wins", bad_id_o, 1);
    chk("s6_ovf_quiet", ovf_o, 3'b000);

    step();
    chk("end_q0_left", q0.size(), 0);
    chk("end_q1_left", q1.size(), 0);
    chk("end_q2_left", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
